// File: rtl/bus_responder_if.sv
// Processor-side word bus: address, write data and strobe out; registered read data back.
interface bus_responder_if;
    logic [31:0] ADDR;
    logic [31:0] DOUT;
    logic        W;
    logic [31:0] DIN;

    modport master (output ADDR, output DOUT, output W, input DIN);
    modport slave  (input ADDR, input DOUT, input W, output DIN);
endinterface

// File: rtl/bus_responder.sv
// Far-end bus responder: data RAM, LED register, synchronized switches and a compare/match timer.
// Read data is registered (one-cycle latency, read-first); unmapped writes raise a sticky error.
module bus_responder #(
    parameter int unsigned AW    = 8,
    parameter int unsigned LED_W = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    bus_responder_if.slave   bus,
    input  logic [LED_W-1:0] SW,
    output logic [LED_W-1:0] LEDR,
    output logic             irq,
    output logic             bus_err
);
    localparam int unsigned DEPTH  = 2 ** AW;
    localparam logic [31:0] A_LED  = 32'h0000_1000;
    localparam logic [31:0] A_SW   = 32'h0000_2000;
    localparam logic [31:0] A_CNT  = 32'h0000_3000;
    localparam logic [31:0] A_CMP  = 32'h0000_3001;
    localparam logic [31:0] A_STS  = 32'h0000_3002;
    localparam logic [31:0] A_CTL  = 32'h0000_3003;

    logic [31:0]      mem [DEPTH];
    logic [AW-1:0]    ram_idx;
    logic             hit_ram, hit_led, hit_sw, hit_cnt, hit_cmp, hit_sts, hit_ctl, mapped;

    logic [31:0]      din_q, din_d;
    logic [LED_W-1:0] led_q, led_d;
    logic [LED_W-1:0] sw_meta_q, sw_meta_d;
    logic [LED_W-1:0] sw_sync_q, sw_sync_d;
    logic [31:0]      count_q, count_d;
    logic [31:0]      compare_q, compare_d;
    logic             match_q, match_d;
    logic [2:0]       ctrl_q, ctrl_d;   // {irq_en, auto_reload, en}
    logic             irq_q, irq_d;
    logic             err_q, err_d;

    // Address decode, read mux and next-state for all registers
    always_comb begin
        ram_idx = bus.ADDR[AW-1:0];
        hit_ram = (bus.ADDR[31:AW] == '0);
        hit_led = (bus.ADDR == A_LED);
        hit_sw  = (bus.ADDR == A_SW);
        hit_cnt = (bus.ADDR == A_CNT);
        hit_cmp = (bus.ADDR == A_CMP);
        hit_sts = (bus.ADDR == A_STS);
        hit_ctl = (bus.ADDR == A_CTL);
        mapped  = hit_ram | hit_led | hit_sw | hit_cnt | hit_cmp | hit_sts | hit_ctl;

        din_d = '0;
        if (hit_ram)      din_d = mem[ram_idx];
        else if (hit_led) din_d = 32'(led_q);
        else if (hit_sw)  din_d = 32'(sw_sync_q);
        else if (hit_cnt) din_d = count_q;
        else if (hit_cmp) din_d = compare_q;
        else if (hit_sts) din_d = {31'd0, match_q};
        else if (hit_ctl) din_d = {29'd0, ctrl_q};

        led_d     = led_q;
        sw_meta_d = SW;
        sw_sync_d = sw_meta_q;
        count_d   = count_q;
        compare_d = compare_q;
        match_d   = match_q;
        ctrl_d    = ctrl_q;
        err_d     = err_q | (bus.W & ~mapped);

        if (bus.W && hit_led) led_d     = bus.DOUT[LED_W-1:0];
        if (bus.W && hit_cmp) compare_d = bus.DOUT;
        if (bus.W && hit_ctl) ctrl_d    = bus.DOUT[2:0];
        if (bus.W && hit_sts && bus.DOUT[0]) match_d = 1'b0;

        // Timer uses pre-edge ctrl/compare; a new match overrides the W1C above
        if (bus.W && hit_cnt) begin
            count_d = bus.DOUT;
        end else if (ctrl_q[0]) begin
            if (count_q == compare_q) begin
                match_d = 1'b1;
                count_d = ctrl_q[1] ? 32'd0 : count_q + 32'd1;
            end else begin
                count_d = count_q + 32'd1;
            end
        end

        irq_d = match_d & ctrl_d[2];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            din_q     <= '0;
            led_q     <= '0;
            sw_meta_q <= '0;
            sw_sync_q <= '0;
            count_q   <= '0;
            compare_q <= '1;
            match_q   <= 1'b0;
            ctrl_q    <= '0;
            irq_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            din_q     <= din_d;
            led_q     <= led_d;
            sw_meta_q <= sw_meta_d;
            sw_sync_q <= sw_sync_d;
            count_q   <= count_d;
            compare_q <= compare_d;
            match_q   <= match_d;
            ctrl_q    <= ctrl_d;
            irq_q     <= irq_d;
            err_q     <= err_d;
        end
    end

    // RAM array is not reset; writes are blocked while reset is asserted
    always_ff @(posedge clk) begin
        if (rst_n && bus.W && hit_ram) mem[ram_idx] <= bus.DOUT;
    end

    assign bus.DIN = din_q;
    assign LEDR    = led_q;
    assign irq     = irq_q;
    assign bus_err = err_q;
endmodule

// File: tb/tb_bus_responder.sv
// Bench for bus_responder: directed bus transactions, a transaction-level reference model
// checked every cycle, and hand-computed literal expectations at key points.
module tb_bus_responder;
    localparam int unsigned AW    = 8;
    localparam int unsigned LED_W = 10;
    localparam logic [31:0] RAM_WORDS = 32'(2 ** AW);

    logic             clk = 1'b0;
    logic             rst_n;
    logic [LED_W-1:0] SW;
    logic [LED_W-1:0] LEDR;
    logic             irq;
    logic             bus_err;

    bus_responder_if bus();

    bus_responder #(.AW(AW), .LED_W(LED_W)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .SW(SW), .LEDR(LEDR), .irq(irq), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit started = 1'b0;

    // Reference model state
    logic [31:0]      m_ram [int];
    logic [LED_W-1:0] m_led;
    logic [LED_W-1:0] m_sw_pipe [2];
    logic [31:0]      m_count, m_compare, m_din;
    bit               m_match, m_en, m_reload, m_irqen, m_err, m_irq, m_din_known;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic logic [31:0] m_read(input logic [31:0] a, output bit known);
        known = 1'b1;
        if (a < RAM_WORDS) begin
            if (m_ram.exists(int'(a))) return m_ram[int'(a)];
            known = 1'b0;
            return 32'd0;
        end
        case (a)
            32'h1000: return 32'(m_led);
            32'h2000: return 32'(m_sw_pipe[1]);
            32'h3000: return m_count;
            32'h3001: return m_compare;
            32'h3002: return 32'(m_match);
            32'h3003: return {29'd0, m_irqen, m_reload, m_en};
            default:  return 32'd0;
        endcase
    endfunction

    // Model: one bus transaction per rising edge
    always @(posedge clk) begin
        logic [31:0] a, d;
        bit          w, old_en, old_reload;
        logic [31:0] old_cmp;
        if (!rst_n) begin
            m_din = 32'd0; m_din_known = 1'b1; m_led = '0;
            m_sw_pipe[0] = '0; m_sw_pipe[1] = '0;
            m_count = 32'd0; m_compare = 32'hFFFF_FFFF; m_match = 1'b0;
            m_en = 1'b0; m_reload = 1'b0; m_irqen = 1'b0; m_err = 1'b0;
        end else begin
            a = bus.ADDR; d = bus.DOUT; w = bus.W;
            m_din = m_read(a, m_din_known);
            m_sw_pipe[1] = m_sw_pipe[0];
            m_sw_pipe[0] = SW;
            old_en = m_en; old_reload = m_reload; old_cmp = m_compare;
            if (w) begin
                if (a < RAM_WORDS) m_ram[int'(a)] = d;
                else case (a)
                    32'h1000: m_led = d[LED_W-1:0];
                    32'h2000, 32'h3000: ;
                    32'h3001: m_compare = d;
                    32'h3002: if (d[0]) m_match = 1'b0;
                    32'h3003: {m_irqen, m_reload, m_en} = d[2:0];
                    default:  m_err = 1'b1;
                endcase
            end
            if (w && a == 32'h3000) m_count = d;
            else if (old_en) begin
                if (m_count == old_cmp) begin
                    m_match = 1'b1;
                    m_count = old_reload ? 32'd0 : m_count + 32'd1;
                end else begin
                    m_count = m_count + 32'd1;
                end
            end
        end
        m_irq = m_match & m_irqen;
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (started) begin
            if (m_din_known) chk("din_model", bus.DIN, m_din);
            chk("ledr_model", 32'(LEDR), 32'(m_led));
            chk("irq_model", 32'(irq), 32'(m_irq));
            chk("bus_err_model", 32'(bus_err), 32'(m_err));
        end
    end

    task automatic apply(input bit w, input logic [31:0] a, input logic [31:0] d);
        bus.W = w; bus.ADDR = a; bus.DOUT = d;
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n = 1'b0; SW = '0;
        bus.W = 1'b0; bus.ADDR = '0; bus.DOUT = '0;
        apply(0, 32'h0, 32'h0);
        started = 1'b1;
        apply(0, 32'h0, 32'h0);
        chk("rst_din", bus.DIN, 32'h0);
        chk("rst_ledr", 32'(LEDR), 32'h0);
        chk("rst_irq", 32'(irq), 32'h0);
        chk("rst_bus_err", 32'(bus_err), 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 32; i++) apply(1, 32'(i), 32'h0);

        // RAM write/read and read-first
        apply(1, 32'h05, 32'hDEAD_BEEF);
        apply(0, 32'h05, 32'h0);
        chk("ram_rd", bus.DIN, 32'hDEAD_BEEF);
        apply(0, 32'h06, 32'h0);
        chk("ram_unwritten", bus.DIN, 32'h0);
        apply(1, 32'h10, 32'h1111_1111);
        apply(1, 32'h10, 32'h2222_2222);
        chk("read_first_old", bus.DIN, 32'h1111_1111);
        apply(0, 32'h10, 32'h0);
        chk("read_first_new", bus.DIN, 32'h2222_2222);

        // LED register, unmapped reads
        apply(1, 32'h1000, 32'h3FF);
        chk("ledr_write", 32'(LEDR), 32'h3FF);
        apply(0, 32'h1000, 32'h0);
        chk("ledr_readback", bus.DIN, 32'h0000_03FF);
        apply(0, 32'h1001, 32'h0);
        chk("unmapped_rd_1001", bus.DIN, 32'h0);
        apply(0, 32'h3004, 32'h0);
        chk("unmapped_rd_3004", bus.DIN, 32'h0);

        // Switch synchronizer latency
        SW = 10'h155;
        apply(0, 32'h2000, 32'h0);
        chk("sw_edge1", bus.DIN, 32'h0);
        apply(0, 32'h2000, 32'h0);
        chk("sw_edge2", bus.DIN, 32'h0);
        apply(0, 32'h2000, 32'h0);
        chk("sw_edge3", bus.DIN, 32'h155);
        apply(1, 32'h2000, 32'h0);
        chk("sw_write_no_err", 32'(bus_err), 32'h0);

        // Periodic timer: compare=5, ctrl=en|auto_reload|irq_en at E0
        apply(1, 32'h3001, 32'd5);
        apply(1, 32'h3003, 32'h7);
        for (int k = 1; k <= 6; k++) begin
            apply(0, 32'h3000, 32'h0);
            chk($sformatf("count_before_E%0d", k), bus.DIN, 32'(k - 1));
        end
        chk("irq_E6", 32'(irq), 32'h1);
        apply(0, 32'h3002, 32'h0);
        chk("status_E7", bus.DIN, 32'h1);
        apply(1, 32'h3002, 32'h1);
        chk("irq_w1c_E8", 32'(irq), 32'h0);
        repeat (3) apply(0, 32'h3000, 32'h0);
        chk("irq_E11", 32'(irq), 32'h0);
        apply(0, 32'h3000, 32'h0);
        chk("count_before_E12", bus.DIN, 32'd5);
        chk("irq_E12", 32'(irq), 32'h1);

        // W1C on the same edge as a match: set wins
        apply(1, 32'h3002, 32'h1);
        chk("irq_E13", 32'(irq), 32'h0);
        repeat (4) apply(0, 32'h3000, 32'h0);
        apply(1, 32'h3002, 32'h1);
        chk("irq_w1c_collide", 32'(irq), 32'h1);
        apply(0, 32'h3002, 32'h0);
        chk("status_w1c_collide", bus.DIN, 32'h1);

        // Count write while running
        apply(1, 32'h3000, 32'h100);
        apply(0, 32'h3000, 32'h0);
        chk("count_load", bus.DIN, 32'h100);
        apply(0, 32'h3000, 32'h0);
        chk("count_load_inc", bus.DIN, 32'h101);

        // Wrap without auto-reload
        apply(1, 32'h3003, 32'h0);
        apply(1, 32'h3002, 32'h1);
        apply(1, 32'h3001, 32'hFFFF_FFFF);
        apply(1, 32'h3000, 32'hFFFF_FFFE);
        apply(1, 32'h3003, 32'h5);
        apply(0, 32'h3000, 32'h0);
        chk("wrap_count_a", bus.DIN, 32'hFFFF_FFFE);
        chk("wrap_irq_a", 32'(irq), 32'h0);
        apply(0, 32'h3000, 32'h0);
        chk("wrap_count_b", bus.DIN, 32'hFFFF_FFFF);
        chk("wrap_irq_b", 32'(irq), 32'h1);
        apply(0, 32'h3000, 32'h0);
        chk("wrap_count_c", bus.DIN, 32'h0);
        apply(1, 32'h3002, 32'h1);
        chk("wrap_irq_cleared", 32'(irq), 32'h0);
        repeat (5) apply(0, 32'h3002, 32'h0);
        chk("wrap_single_match", bus.DIN, 32'h0);

        // Unmapped write: sticky error, RAM alias untouched
        apply(1, 32'h0001_0000, 32'h0000_0BAD);
        chk("bus_err_set", 32'(bus_err), 32'h1);
        apply(0, 32'h0, 32'h0);
        chk("ram_alias_untouched", bus.DIN, 32'h0);
        apply(0, 32'h0, 32'h0);
        chk("bus_err_sticky", 32'(bus_err), 32'h1);
        apply(1, 32'h1000, 32'h2AA);

        // Mid-operation reset with the timer running
        rst_n = 1'b0;
        apply(1, 32'h1000, 32'h155);
        chk("mid_rst_din", bus.DIN, 32'h0);
        chk("mid_rst_ledr", 32'(LEDR), 32'h0);
        chk("mid_rst_irq", 32'(irq), 32'h0);
        chk("mid_rst_bus_err", 32'(bus_err), 32'h0);
        rst_n = 1'b1;
        apply(0, 32'h3000, 32'h0);
        chk("mid_rst_count", bus.DIN, 32'h0);
        apply(0, 32'h3001, 32'h0);
        chk("mid_rst_compare", bus.DIN, 32'hFFFF_FFFF);
        apply(0, 32'h3002, 32'h0);
        chk("mid_rst_status", bus.DIN, 32'h0);
        apply(0, 32'h3003, 32'h0);
        chk("mid_rst_ctrl", bus.DIN, 32'h0);
        apply(0, 32'h3000, 32'h0);
        chk("mid_rst_frozen", bus.DIN, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
